// File: rtl/mario_pkg.sv
// Shared definitions for the player-side blocks. The key constants live here
// so the movement block and the jump block decode keys the same way.
package mario_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } jump_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

endpackage

// File: rtl/jump_controller_if.sv
// Per-frame signals exchanged between the frame/collision logic (master)
// and the jump controller (slave).
interface jump_controller_if;

    logic        frame_tick;
    logic [31:0] keycode;
    logic        on_ground;
    logic        hit_ceiling;
    logic [9:0]  jump_x_motion;
    logic [9:0]  jump_y_motion;
    logic        jump_active;
    logic [1:0]  state_o;

    modport master (
        output frame_tick, keycode, on_ground, hit_ceiling,
        input  jump_x_motion, jump_y_motion, jump_active, state_o
    );

    modport slave (
        input  frame_tick, keycode, on_ground, hit_ceiling,
        output jump_x_motion, jump_y_motion, jump_active, state_o
    );

endinterface

// File: rtl/keycode_decode.sv
// Combinational key decode: a key counts as held if any of the four HID
// report bytes carries its code.
module keycode_decode
    import mario_pkg::*;
(
    input  logic [31:0] keycode,
    output logic        key_w,
    output logic        key_a,
    output logic        key_d
);

    // Scan all four bytes for the W, A and D codes.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        key_w = 1'b0;
        key_a = 1'b0;
        key_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[8*i +: 8] == KEY_W) key_w = 1'b1;
            if (keycode[8*i +: 8] == KEY_A) key_a = 1'b1;
            if (keycode[8*i +: 8] == KEY_D) key_d = 1'b1;
        end
    end

endmodule

// File: rtl/jump_controller.sv
// Jump/fall motion generator for the player sprite. Runs a rise/fall state
// machine once per video frame and presents signed per-frame deltas that the
// player block adds to its position.
module jump_controller
    import mario_pkg::*;
#(
    parameter int JUMP_V   = 8,
    parameter int GRAV_DIV = 2,
    parameter int MAX_FALL = 8,
    parameter int AIR_X_V  = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    jump_controller_if.slave   bus
);

    localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(GRAV_DIV - 1);
    localparam logic signed [9:0] VY_TAKEOFF = 10'(-JUMP_V);
    localparam logic signed [9:0] VY_MAX     = 10'(MAX_FALL);
    localparam logic signed [9:0] VX_AIR     = 10'(AIR_X_V);

    jump_state_t       state, state_n;
    logic signed [9:0] vx, vx_n;
    logic signed [9:0] vy, vy_n;
    logic [CNT_W-1:0]  grav_cnt, grav_cnt_n;
    logic              w_prev;

    logic              key_w, key_a, key_d;
    logic              jump_req;
    logic              grav_step;
    logic signed [9:0] vy_inc;
    logic signed [9:0] vx_takeoff;

    keycode_decode u_decode (
        .keycode (bus.keycode),
        .key_w   (key_w),
        .key_a   (key_a),
        .key_d   (key_d)
    );

    // Derived per-tick conditions shared by the next-state logic.
    always_comb begin
        jump_req  = key_w & ~w_prev;
        grav_step = (grav_cnt == CNT_LAST);
        vy_inc    = vy + 10'sd1;
        if (key_a && !key_d)      vx_takeoff = -VX_AIR;
        else if (key_d && !key_a) vx_takeoff = VX_AIR;
        else                      vx_takeoff = '0;
    end

    // Next-state, velocity and gravity-counter logic.
    always_comb begin
        state_n    = state;
        vx_n       = vx;
        vy_n       = vy;
        grav_cnt_n = grav_cnt;
        unique case (state)
            IDLE: begin
                vx_n       = '0;
                vy_n       = '0;
                grav_cnt_n = '0;
                // Walking off a ledge wins over a jump request on the same tick.
                if (!bus.on_ground) begin
                    state_n = FALL;
                end else if (jump_req) begin
                    state_n = RISE;
                    vy_n    = VY_TAKEOFF;
                    vx_n    = vx_takeoff;
                end
            end
            RISE: begin
                if (bus.hit_ceiling) begin
                    state_n    = FALL;
                    vy_n       = '0;
                    grav_cnt_n = '0;
                end else if (grav_step) begin
                    vy_n       = vy_inc;
                    grav_cnt_n = '0;
                    if (vy_inc == 10'sd0) state_n = FALL;
                end else begin
                    grav_cnt_n = grav_cnt + 1'b1;
                end
            end
            FALL: begin
                if (bus.on_ground) begin
                    state_n    = IDLE;
                    vx_n       = '0;
                    vy_n       = '0;
                    grav_cnt_n = '0;
                end else if (grav_step) begin
                    vy_n       = (vy >= VY_MAX) ? VY_MAX : vy_inc;
                    grav_cnt_n = '0;
                end else begin
                    grav_cnt_n = grav_cnt + 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                vx_n       = '0;
                vy_n       = '0;
                grav_cnt_n = '0;
            end
        endcase
    end

    // Frame-rate state update; everything holds between frame ticks.
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: async reset clears the whole FSM so a mid-jump reset zeroes the outputs at once.
        if (!Reset_n) begin
            state    <= IDLE;
            vx       <= '0;
            vy       <= '0;
            grav_cnt <= '0;
            w_prev   <= 1'b0;
        end else if (bus.frame_tick) begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state    <= state_n;
            vx       <= vx_n;
            vy       <= vy_n;
            grav_cnt <= grav_cnt_n;
            w_prev   <= key_w;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        bus.jump_x_motion = vx;
        bus.jump_y_motion = vy;
        bus.jump_active   = (state != IDLE);
        bus.state_o       = state;
    end

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller with default parameters.
module tb_jump_controller;

    logic Clk;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;

    jump_controller_if bus ();

    jump_controller #(
        .JUMP_V   (8),
        .GRAV_DIV (2),
        .MAX_FALL (8),
        .AIR_X_V  (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [1:0] st);
        check({tag, ".x"},      32'(bus.jump_x_motion), 32'(x));
        check({tag, ".y"},      32'(bus.jump_y_motion), 32'(y));
        check({tag, ".state"},  32'(bus.state_o),       32'(st));
        check({tag, ".active"}, 32'(bus.jump_active),   32'(st != 2'd0));
    endtask

    // One frame tick: called at a falling edge, returns at the next falling edge.
    task automatic do_tick();
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        Reset_n         = 1'b0;
        bus.frame_tick  = 1'b0;
        bus.keycode     = 32'h0;
        bus.on_ground   = 1'b1;
        bus.hit_ceiling = 1'b0;
        repeat (2) @(negedge Clk);
        check_all("reset", 10'h000, 10'h000, 2'd0);
        Reset_n = 1'b1;

        do_tick();
        check_all("idle_hold", 10'h000, 10'h000, 2'd0);

        // D-only takeoff, W and D in the upper bytes.
        bus.keycode = 32'h071A0000;
        do_tick();
        check_all("takeoff_d", 10'h002, 10'h3F8, 2'd1);
        bus.keycode   = 32'h0;
        bus.on_ground = 1'b0;
        do_tick();
        check_all("rise_t1", 10'h002, 10'h3F8, 2'd1);
        do_tick();
        check_all("rise_t2", 10'h002, 10'h3F9, 2'd1);
        repeat (14) do_tick();
        check_all("apex_t16", 10'h002, 10'h000, 2'd2);
        repeat (2) do_tick();
        check_all("fall_t18", 10'h002, 10'h001, 2'd2);
        bus.on_ground = 1'b1;
        do_tick();
        check_all("land1", 10'h000, 10'h000, 2'd0);

        // W+A takeoff, D during flight must not steer.
        bus.keycode = 32'h00001A04;
        do_tick();
        check_all("takeoff_a", 10'h3FE, 10'h3F8, 2'd1);
        bus.keycode   = 32'h00000007;
        bus.on_ground = 1'b0;
        repeat (16) do_tick();
        check_all("no_steer", 10'h3FE, 10'h000, 2'd2);
        bus.on_ground = 1'b1;
        do_tick();
        check_all("land2", 10'h000, 10'h000, 2'd0);

        // W held through a landing; A+D together give no horizontal speed.
        bus.keycode = 32'h1A070400;
        do_tick();
        check_all("takeoff_ad", 10'h000, 10'h3F8, 2'd1);
        bus.on_ground = 1'b0;
        repeat (16) do_tick();
        check_all("apex_hold_w", 10'h000, 10'h000, 2'd2);
        bus.on_ground = 1'b1;
        do_tick();
        check_all("land3", 10'h000, 10'h000, 2'd0);
        do_tick();
        check_all("no_retrigger", 10'h000, 10'h000, 2'd0);
        bus.keycode = 32'h0;
        do_tick();
        check_all("released", 10'h000, 10'h000, 2'd0);
        bus.keycode = 32'h0000001A;
        do_tick();
        check_all("retrigger", 10'h000, 10'h3F8, 2'd1);

        // Ceiling at vy=-6 on a tick where gravity would also step.
        bus.on_ground = 1'b0;
        repeat (5) do_tick();
        check_all("rise_m6", 10'h000, 10'h3FA, 2'd1);
        bus.hit_ceiling = 1'b1;
        do_tick();
        check_all("ceiling", 10'h000, 10'h000, 2'd2);
        bus.hit_ceiling = 1'b0;
        repeat (2) do_tick();
        check_all("fall_v1", 10'h000, 10'h001, 2'd2);
        repeat (14) do_tick();
        check_all("fall_v8", 10'h000, 10'h008, 2'd2);
        repeat (24) do_tick();
        check_all("fall_sat", 10'h000, 10'h008, 2'd2);
        bus.on_ground = 1'b1;
        do_tick();
        check_all("land4", 10'h000, 10'h000, 2'd0);

        // Ledge and W press on the same tick: ledge wins.
        bus.keycode = 32'h0;
        do_tick();
        bus.on_ground = 1'b0;
        bus.keycode   = 32'h0000001A;
        do_tick();
        check_all("ledge_wins", 10'h000, 10'h000, 2'd2);
        bus.keycode = 32'h0;
        repeat (2) do_tick();
        check_all("ledge_fall", 10'h000, 10'h001, 2'd2);

        // No frame tick: nothing may change whatever the inputs do.
        bus.on_ground   = 1'b1;
        bus.hit_ceiling = 1'b1;
        bus.keycode     = 32'h00001A04;
        repeat (100) @(negedge Clk);
        check_all("no_tick", 10'h000, 10'h001, 2'd2);
        bus.hit_ceiling = 1'b0;
        bus.keycode     = 32'h0;

        // Landing beats a gravity step on the same tick.
        bus.on_ground = 1'b0;
        do_tick();
        check_all("pre_land", 10'h000, 10'h001, 2'd2);
        bus.on_ground = 1'b1;
        do_tick();
        check_all("land_prio", 10'h000, 10'h000, 2'd0);

        // Asynchronous reset in the middle of a rise.
        bus.keycode = 32'h0000001A;
        do_tick();
        bus.on_ground = 1'b0;
        repeat (6) do_tick();
        check_all("rise_m5", 10'h000, 10'h3FB, 2'd1);
        #2 Reset_n = 1'b0;
        #1 check_all("async_reset", 10'h000, 10'h000, 2'd0);
        @(negedge Clk);
        Reset_n       = 1'b1;
        bus.keycode   = 32'h0;
        bus.on_ground = 1'b1;
        do_tick();
        check_all("post_reset", 10'h000, 10'h000, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
